// File: rtl/data_tile_feeder.sv
// Assembles a row-major element stream into 6x6 tiles and presents each tile REPEAT times (ping-pong).
// Latency: a tile is valid the cycle after its 36th element is accepted; a freed buffer accepts again the next cycle.
// Backpressure: elem_ready_o drops only when both buffers are FULL; the presented tile holds while tile_ready_i is low.
module data_tile_feeder #(
    parameter int DW     = 14,
    parameter int TILE   = 6,
    parameter int IDX_W  = 9,
    parameter int REPEAT = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic signed [DW-1:0]                   elem_i,
    input  logic                                   elem_valid_i,
    output logic                                   elem_ready_o,
    input  logic        [IDX_W-1:0]                tile_x_i,
    input  logic        [IDX_W-1:0]                tile_y_i,
    output logic signed [TILE-1:0][TILE-1:0][DW-1:0] data_tile_o,
    output logic                                   data_valid_o,
    output logic        [IDX_W-1:0]                data_x_index_o,
    output logic        [IDX_W-1:0]                data_y_index_o,
    output logic        [7:0]                      data_rep_o,
    input  logic                                   tile_ready_i
);

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_FILLING = 2'd1,
        BUF_FULL    = 2'd2
    } buf_state_t;

    localparam logic [2:0] LAST_RC  = 3'(TILE - 1);
    localparam logic [7:0] LAST_REP = 8'(REPEAT - 1);

    typedef logic [TILE-1:0][TILE-1:0][DW-1:0] tile_t;

    buf_state_t       state_q [2];
    buf_state_t       state_d [2];
    tile_t            buf_mem [2];
    logic [IDX_W-1:0] buf_x   [2];
    logic [IDX_W-1:0] buf_y   [2];
    logic             wptr;
    logic             rptr;
    logic [2:0]       row;
    logic [2:0]       col;
    logic [7:0]       rep;

    logic accept;
    logic last_elem;
    logic xfer;
    logic last_rep;

    assign elem_ready_o = !reset && (state_q[wptr] != BUF_FULL);
    assign accept       = elem_valid_i && elem_ready_o;
    assign last_elem    = (row == LAST_RC) && (col == LAST_RC);

    assign data_valid_o   = (state_q[rptr] == BUF_FULL);
    assign data_tile_o    = buf_mem[rptr];
    assign data_x_index_o = buf_x[rptr];
    assign data_y_index_o = buf_y[rptr];
    assign data_rep_o     = rep;
    assign xfer           = data_valid_o && tile_ready_i;
    assign last_rep       = (rep == LAST_REP);

    // Fill and free may hit different buffers in one cycle; they cannot hit the
    // same one since accept needs !FULL and transfer needs FULL.
    always_comb begin
        state_d[0] = state_q[0];
        state_d[1] = state_q[1];
        if (accept) begin
            state_d[wptr] = last_elem ? BUF_FULL : BUF_FILLING;
        end
        if (xfer && last_rep) begin
            state_d[rptr] = BUF_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q[0] <= BUF_EMPTY;
            state_q[1] <= BUF_EMPTY;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            buf_x[0]   <= '0;
            buf_x[1]   <= '0;
            buf_y[0]   <= '0;
            buf_y[1]   <= '0;
            wptr       <= 1'b0;
            rptr       <= 1'b0;
            row        <= '0;
            col        <= '0;
            rep        <= '0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];

            if (accept) begin
                buf_mem[wptr][row][col] <= elem_i;
                if (row == 3'd0 && col == 3'd0) begin
                    buf_x[wptr] <= tile_x_i;
                    buf_y[wptr] <= tile_y_i;
                end
                if (last_elem) begin
                    wptr <= ~wptr;
                    row  <= '0;
                    col  <= '0;
                end else if (col == LAST_RC) begin
                    col <= '0;
                    row <= row + 3'd1;
                end else begin
                    col <= col + 3'd1;
                end
            end

            if (xfer) begin
                if (last_rep) begin
                    rep  <= '0;
                    rptr <= ~rptr;
                end else begin
                    rep <= rep + 8'd1;
                end
            end
        end
    end

endmodule
